// File: rtl/ntable_pkg.sv
// Shared constants and helpers for the nametable scheduler.
// Holds the VGA timing defaults, the NES active window (512x480), the
// 16-column tile group, the 2-cycle fetch lookahead and the tile address
// packing {row, column} used to index the 32x30 nametable.
package ntable_pkg;

  localparam int NT_HTOTAL   = 800;
  localparam int NT_VTOTAL   = 525;
  localparam int NT_ACT_W    = 512;
  localparam int NT_ACT_H    = 480;
  localparam int NT_TILE_W   = 16;
  localparam int NT_FETCH_OFS = 2;

  // Column phase inside a tile group on which the next group is fetched.
  localparam logic [3:0] NT_SLOT_PHASE = 4'(NT_TILE_W - NT_FETCH_OFS);

  // Row-major nametable address: 5-bit tile row, 5-bit tile column.
  function automatic logic [9:0] tile_addr(input logic [4:0] row,
                                           input logic [4:0] tcol);
    return {row, tcol};
  endfunction

endpackage

// File: rtl/ntable_wfifo.sv
// Small synchronous write FIFO holding {addr, data} pairs for the nametable.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (flushes FIFO)
//   push, push_addr/data  enqueue request (ignored when full)
//   pop                   dequeue head (ignored when empty)
//   head_addr/data        current head entry
//   full, empty, count    occupancy status
module ntable_wfifo #(
  parameter int C_AW        = 10,
  parameter int C_MEMW      = 8,
  parameter int C_FIFO_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [C_AW-1:0]        push_addr,
  input  logic [C_MEMW-1:0]      push_data,
  input  logic                   pop,
  output logic [C_AW-1:0]        head_addr,
  output logic [C_MEMW-1:0]      head_data,
  output logic                   full,
  output logic                   empty,
  output logic [C_FIFO_LOG2:0]   count
);

  localparam int DEPTH = 2 ** C_FIFO_LOG2;
  localparam logic [C_FIFO_LOG2:0]   DEPTH_C = (C_FIFO_LOG2 + 1)'(DEPTH);
  localparam logic [C_FIFO_LOG2:0]   CNT_ONE = (C_FIFO_LOG2 + 1)'(1);
  localparam logic [C_FIFO_LOG2-1:0] PTR_ONE = C_FIFO_LOG2'(1);

  logic [C_AW+C_MEMW-1:0] store [DEPTH];
  logic [C_FIFO_LOG2-1:0] wr_ptr;
  logic [C_FIFO_LOG2-1:0] rd_ptr;
  logic                   push_ok;
  logic                   pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign {head_addr, head_data} = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= {push_addr, push_data};
  end

endmodule

// File: rtl/ntable_sched.sv
// Nametable RAM scheduler: shares the single-port nametable RAM between the
// background tile prefetch (fixed slots) and a buffered write requester.
// Optional build macro: NTSCHED_BLANK_ONLY_EN -- when defined, queued writes
//   are drained only while visible=0; otherwise in any non-fetch cycle.
// Ports:
//   clk, rst_n        clock (one pixel per cycle), synchronous active-low reset
//   visible, col, fila VGA timing inputs
//   tile_q            tile byte for the current 16-column group, to the PPU
//   wr_req/addr/data  write request; wr_ack (combinational) accepts it
//   fifo_cnt          pending write count
//   ram_addr/we/wdata registered RAM controls; ram_rdata read data
module ntable_sched
  import ntable_pkg::*;
#(
  parameter int C_MEMW      = 8,
  parameter int C_AW        = 10,
  parameter int C_FIFO_LOG2 = 2,
  parameter int C_HTOTAL    = NT_HTOTAL,
  parameter int C_VTOTAL    = NT_VTOTAL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 visible,
  input  logic [9:0]           col,
  input  logic [9:0]           fila,
  output logic [C_MEMW-1:0]    tile_q,
  input  logic                 wr_req,
  input  logic [C_AW-1:0]      wr_addr,
  input  logic [C_MEMW-1:0]    wr_data,
  output logic                 wr_ack,
  output logic [C_FIFO_LOG2:0] fifo_cnt,
  output logic [C_AW-1:0]      ram_addr,
  output logic                 ram_we,
  output logic [C_MEMW-1:0]    ram_wdata,
  input  logic [C_MEMW-1:0]    ram_rdata
);

  localparam logic [10:0] HTOT       = 11'(C_HTOTAL);
  localparam logic [10:0] COL_WRAPF  = 11'(C_HTOTAL - NT_FETCH_OFS);
  localparam logic [10:0] ACT_W      = 11'(NT_ACT_W);
  localparam logic [9:0]  ACT_H      = 10'(NT_ACT_H);
  localparam logic [9:0]  VLAST      = 10'(C_VTOTAL - 1);

  logic [10:0]       col_ahead;
  logic              line_wrap;
  logic [9:0]        fila_ahead;
  logic [4:0]        tcol_ahead;
  logic              slot;
  logic [C_AW-1:0]   fetch_addr;
  logic              drain_ok;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [C_AW-1:0]   head_addr;
  logic [C_MEMW-1:0] head_data;
  logic              fetch_vld_p1;

  // Fetch slot decode, looking at the pixel two cycles ahead.
  always_comb begin
    col_ahead  = {1'b0, col} + 11'(NT_FETCH_OFS);
    line_wrap  = (col_ahead >= HTOT);
    fila_ahead = fila;
    if (line_wrap) fila_ahead = (fila == VLAST) ? '0 : fila + 10'd1;
    // The lookahead is shorter than a tile group, so a wrapped pixel is
    // always inside tile column 0.
    tcol_ahead = line_wrap ? 5'd0 : col_ahead[8:4];
    slot = 1'b0;
    if ((col[3:0] == NT_SLOT_PHASE) && (col_ahead < ACT_W) && (fila < ACT_H))
      slot = 1'b1;
    if (({1'b0, col} == COL_WRAPF) && (fila_ahead < ACT_H))
      slot = 1'b1;
  end

  assign fetch_addr = C_AW'(tile_addr(fila_ahead[8:4], tcol_ahead));

`ifdef NTSCHED_BLANK_ONLY_EN
  assign drain_ok = ~visible;
`else
  logic unused_visible;
  assign drain_ok       = 1'b1;
  assign unused_visible = visible;
`endif

  // Acceptance uses the count before any same-cycle pop.
  assign wr_ack = wr_req & ~fifo_full & rst_n;
  assign pop    = ~slot & ~fifo_empty & drain_ok;

  ntable_wfifo #(
    .C_AW        (C_AW),
    .C_MEMW      (C_MEMW),
    .C_FIFO_LOG2 (C_FIFO_LOG2)
  ) u_wfifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_ack),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  // Stage p0 -> p1: RAM command issue (fetch wins over a queued write).
  // Stage p1 -> p2: read data of the issued fetch lands in tile_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_addr     <= '0;
      ram_we       <= 1'b0;
      ram_wdata    <= '0;
      tile_q       <= '0;
      fetch_vld_p1 <= 1'b0;
    end else begin
      fetch_vld_p1 <= slot;
      ram_we       <= 1'b0;
      if (slot) begin
        ram_addr <= fetch_addr;
      end else if (pop) begin
        ram_we    <= 1'b1;
        ram_addr  <= head_addr;
        ram_wdata <= head_data;
      end
      if (fetch_vld_p1) tile_q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ntable_sched.sv
module tb_ntable_sched;

  localparam int HT = 800;
  localparam int VT = 525;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       visible;
  logic [9:0] col;
  logic [9:0] fila;
  logic [7:0] tile_q;
  logic       wr_req;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic [2:0] fifo_cnt;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  always #5 clk = ~clk;

  ntable_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .visible   (visible),
    .col       (col),
    .fila      (fila),
    .tile_q    (tile_q),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .fifo_cnt  (fifo_cnt),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Nametable RAM: initialised to mem[a] = a[7:0]; read data follows the
  // address presented on ram_addr, so it is ready in the cycle after issue.
  logic [7:0] mem [1024];
  logic       ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = mem[ram_addr];

  int checks = 0;
  int errors = 0;

  logic [17:0] pend_q [$];   // requests not yet accepted
  logic [17:0] sb_q   [$];   // accepted writes expected on the RAM port

  bit  slot_d1 = 1'b0;
  bit  vis_d1  = 1'b0;
  int  addr_d1 = 0;
  int  exp_tile = 0;
  bit  jump = 1'b0;
  int  jcol, jfila;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (col=%0d fila=%0d)",
               tag, obs, exp, col, fila);
    end
  endtask

  function automatic bit is_slot(input int c, input int f);
    int c2, fn;
    c2 = c + 2;
    fn = f;
    if (c2 >= HT) fn = (f == VT - 1) ? 0 : f + 1;
    if ((c % 16) == 14 && c2 < 512 && f < 480) return 1'b1;
    if (c == HT - 2 && fn < 480) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_fetch_addr(input int c, input int f);
    int c2, fn;
    c2 = c + 2;
    fn = f;
    if (c2 >= HT) begin
      c2 = c2 - HT;
      fn = (f == VT - 1) ? 0 : f + 1;
    end
    return (fn / 16) * 32 + (c2 / 16);
  endfunction

  task automatic drive_req();
    if (pend_q.size() > 0) begin
      wr_req = 1'b1;
      {wr_addr, wr_data} = pend_q[0];
    end else begin
      wr_req  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
    end
  endtask

  task automatic monitor();
    logic [17:0] e;
    chk("tile_q", tile_q, exp_tile);
    if (slot_d1) begin
      chk("fetch_we", ram_we, 0);
      chk("fetch_addr", ram_addr, addr_d1);
    end
    if (ram_we) begin
`ifdef NTSCHED_BLANK_ONLY_EN
      chk("we_in_visible", vis_d1, 0);
`endif
      if (sb_q.size() == 0) begin
        chk("unexpected_write_sb_size", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        chk("write_addr", ram_addr, e[17:8]);
        chk("write_data", ram_wdata, e[7:0]);
      end
    end
  endtask

  task automatic tick();
    bit acked;
    int new_tile;
    acked = wr_req && wr_ack;
    if (acked) sb_q.push_back(pend_q.pop_front());
    new_tile = exp_tile;
    if (!rst_n) begin
      new_tile = 0;
      sb_q.delete();
    end else if (slot_d1) begin
      new_tile = mem[addr_d1];
    end
    vis_d1  = visible;
    slot_d1 = rst_n && is_slot(col, fila);
    addr_d1 = exp_fetch_addr(col, fila);
    @(posedge clk);
    #1;
    exp_tile = new_tile;
    if (jump) begin
      col  = 10'(jcol);
      fila = 10'(jfila);
      jump = 1'b0;
    end else if (col == 10'(HT - 1)) begin
      col  = '0;
      fila = (fila == 10'(VT - 1)) ? '0 : fila + 10'd1;
    end else begin
      col = col + 10'd1;
    end
    visible = (col < 10'd640) && (fila < 10'd480);
    drive_req();
    #1;
    monitor();
  endtask

  task automatic goto_pos(input int c, input int f);
    jump  = 1'b1;
    jcol  = c;
    jfila = f;
    tick();
  endtask

  task automatic run_to(input int c, input int f);
    int n;
    n = 0;
    while (!(col == 10'(c) && fila == 10'(f)) && n < 3000) begin
      tick();
      n++;
    end
    chk("reach_position", int'(n < 3000), 1);
  endtask

  task automatic add_req(input int a, input int d);
    pend_q.push_back({10'(a), 8'(d)});
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    ram_init = 1'b1;
    col      = 10'd700;
    fila     = 10'd490;
    visible  = 1'b0;
    add_req(10'h3FF, 8'h77);
    drive_req();

    // Reset with a request held: nothing accepted, everything cleared.
    tick();
    ram_init = 1'b0;
    tick();
    tick();
    chk("rst_tile_q", tile_q, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_wr_ack", wr_ack, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ack", wr_ack, 1);
    repeat (4) tick();

    // Prefetch of row 9, tile 3.
    goto_pos(30, 146);
    run_to(47, 146);
    chk("pf_addr", ram_addr, 10'h123);
    chk("pf_we", ram_we, 0);
    run_to(48, 146);
    chk("pf_tile48", tile_q, 8'h23);
    run_to(63, 146);
    chk("pf_tile63", tile_q, 8'h23);
    run_to(64, 146);
    chk("pf_tile64", tile_q, 8'h24);

`ifndef NTSCHED_BLANK_ONLY_EN
    // Write requested just before a fetch slot to the address being fetched.
    run_to(44, 147);
    add_req(10'h123, 8'hA5);
    tick();
    chk("col_ack", wr_ack, 1);
    tick();
    chk("col_we46", ram_we, 0);
    chk("col_cnt46", fifo_cnt, 1);
    tick();
    chk("col_we47", ram_we, 0);
    chk("col_addr47", ram_addr, 10'h123);
    chk("col_cnt47", fifo_cnt, 1);
    tick();
    chk("col_we48", ram_we, 1);
    chk("col_wdata48", ram_wdata, 8'hA5);
    chk("col_old_tile", tile_q, 8'h23);
    run_to(48, 148);
    chk("col_new_tile", tile_q, 8'hA5);
`else
    // Writes queued during the visible area wait for blanking.
    goto_pos(100, 200);
    for (int i = 0; i < 5; i++) add_req(10'h300 + i, 8'h60 + i);
    drive_req();
    #1;
    repeat (4) tick();
    chk("full_cnt", fifo_cnt, 4);
    chk("full_ack", wr_ack, 0);
    chk("full_held", pend_q.size(), 1);
    run_to(639, 200);
    chk("full_no_we_visible", ram_we, 0);
    run_to(640, 200);
    chk("full_push_pop_ack", wr_ack, 0);
    tick();
    chk("full_ack_after_pop", wr_ack, 1);
    chk("blank_we641", ram_we, 1);
    tick();
    chk("blank_we642", ram_we, 1);
    run_to(650, 200);
    chk("full_drained_cnt", fifo_cnt, 0);
    chk("full_drained_pend", pend_q.size(), 0);

    // Reset while the FIFO holds three entries.
    goto_pos(100, 201);
    for (int i = 0; i < 3; i++) add_req(10'h310 + i, 8'h90 + i);
    drive_req();
    #1;
    repeat (3) tick();
    chk("rst3_cnt_before", fifo_cnt, 3);
    rst_n = 1'b0;
    tick();
    chk("rst3_cnt", fifo_cnt, 0);
    chk("rst3_we", ram_we, 0);
    chk("rst3_tile", tile_q, 0);
    rst_n = 1'b1;
    tick();
`endif

    // Horizontal wrap: nothing fetched past the active width, then line 0 tile.
    goto_pos(480, 273);
    run_to(798, 273);
    chk("nofetch_addr", ram_addr, 17 * 32 + 31);
    chk("nofetch_we", ram_we, 0);
    run_to(799, 273);
    chk("wrap_addr", ram_addr, 10'h220);
    run_to(0, 274);
    chk("wrap_tile", tile_q, 8'h20);

    // Back-to-back writes in fetch-free blanking.
    goto_pos(100, 490);
    for (int i = 0; i < 5; i++) add_req(10'h3C0 + i, 8'h50 + i);
    drive_req();
    #1;
    n = 0;
    while (pend_q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk("burst_cycles", n, 5);
    repeat (3) tick();
    chk("burst_cnt", fifo_cnt, 0);

    // Vertical wrap: last line fetches tile 0 of line 0; tile_q held meanwhile.
    goto_pos(790, 524);
    run_to(799, 524);
    chk("blank_hold_tile", tile_q, 8'h20);
    chk("vwrap_addr", ram_addr, 0);
    run_to(0, 0);
    chk("vwrap_tile", tile_q, 8'h00);

    repeat (5) tick();
    chk("sb_empty", sb_q.size(), 0);
    chk("pend_empty", pend_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
